// File: rtl/nios2_cpu_debug_ocimem_ctrl_if.sv
// Simple system-bus master port used by the debug memory access engine.
interface nios2_cpu_debug_ocimem_ctrl_if;
  logic [31:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic [31:0] m_readdata;
  logic        m_waitrequest;

  modport master (
    output m_address, m_read, m_write, m_writedata, m_byteenable,
    input  m_readdata, m_waitrequest
  );

  modport slave (
    input  m_address, m_read, m_write, m_writedata, m_byteenable,
    output m_readdata, m_waitrequest
  );
endinterface

// File: rtl/nios2_cpu_debug_ocimem_ctrl.sv
// Debug memory access engine: word reads/writes to a local debug RAM, or to
// the system bus for addresses beyond the RAM, driven by ocimem strobes.
module nios2_cpu_debug_ocimem_ctrl #(
  parameter int unsigned RAM_DEPTH  = 256,
  parameter int unsigned TIMEOUT    = 1023,
  parameter logic [29:0] RESET_ADDR = 30'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  output logic [31:0] MonDReg,
  output logic [29:0] MonAReg,
  output logic        monitor_ready,
  output logic        monitor_error,
  nios2_cpu_debug_ocimem_ctrl_if.master bus
);

  localparam int unsigned AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RAM_RD = 2'd1,
    S_BUS_RD = 2'd2,
    S_BUS_WR = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] tmo_cnt;
  logic [31:0]   ram [RAM_DEPTH];
  logic [31:0]   ram_q;
  logic [AW-1:0] rd_idx;
  logic          cur_hit;
  logic          jdo_hit;
  logic          any_strobe;
  logic          ram_we;
  logic          unused_jdo;

  // Full-width hit tests against the RAM size
  assign cur_hit    = {1'b0, MonAReg} < 31'(RAM_DEPTH);
  assign jdo_hit    = {1'b0, jdo[29:0]} < 31'(RAM_DEPTH);
  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign unused_jdo = ^{jdo[37:36], jdo[33:32]};

  // Address load with read reads the freshly loaded address, not MonAReg
  assign rd_idx = (state == S_IDLE && take_action_ocimem_a) ? jdo[AW-1:0] : MonAReg[AW-1:0];
  assign ram_we = !reset && state == S_IDLE && !take_action_ocimem_a &&
                  take_action_ocimem_b && cur_hit;

  assign bus.m_address = {MonAReg, 2'b00};

  // Debug RAM: synchronous read, write committed only from IDLE outside reset
  always_ff @(posedge clk) begin
    ram_q <= ram[rd_idx];
    if (ram_we) ram[MonAReg[AW-1:0]] <= jdo[31:0];
  end

  // Command FSM with registered monitor and bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      MonDReg          <= '0;
      MonAReg          <= RESET_ADDR;
      monitor_ready    <= 1'b1;
      monitor_error    <= 1'b0;
      bus.m_read       <= 1'b0;
      bus.m_write      <= 1'b0;
      bus.m_writedata  <= '0;
      bus.m_byteenable <= 4'h0;
      tmo_cnt          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take_action_ocimem_a) begin
            MonAReg <= jdo[29:0];
            if (jdo[35]) monitor_error <= 1'b0;
            if (jdo[34]) begin
              monitor_ready <= 1'b0;
              if (jdo_hit) begin
                state <= S_RAM_RD;
              end else begin
                state            <= S_BUS_RD;
                bus.m_read       <= 1'b1;
                bus.m_byteenable <= 4'hF;
              end
            end
          end else if (take_action_ocimem_b) begin
            if (cur_hit) begin
              MonAReg <= MonAReg + 30'd1;
            end else begin
              state            <= S_BUS_WR;
              monitor_ready    <= 1'b0;
              bus.m_write      <= 1'b1;
              bus.m_writedata  <= jdo[31:0];
              bus.m_byteenable <= 4'hF;
            end
          end else if (take_no_action_ocimem_a) begin
            monitor_ready <= 1'b0;
            if (cur_hit) begin
              state <= S_RAM_RD;
            end else begin
              state            <= S_BUS_RD;
              bus.m_read       <= 1'b1;
              bus.m_byteenable <= 4'hF;
            end
          end
        end

        S_RAM_RD: begin
          MonDReg       <= ram_q;
          MonAReg       <= MonAReg + 30'd1;
          monitor_ready <= 1'b1;
          state         <= S_IDLE;
        end

        S_BUS_RD, S_BUS_WR: begin
          if (!bus.m_waitrequest) begin
            if (state == S_BUS_RD) MonDReg <= bus.m_readdata;
            MonAReg          <= MonAReg + 30'd1;
            monitor_ready    <= 1'b1;
            bus.m_read       <= 1'b0;
            bus.m_write      <= 1'b0;
            bus.m_byteenable <= 4'h0;
            tmo_cnt          <= '0;
            state            <= S_IDLE;
          end else if (tmo_cnt == CW'(TIMEOUT)) begin
            if (state == S_BUS_RD) MonDReg <= 32'hDEADDEAD;
            monitor_error    <= 1'b1;
            monitor_ready    <= 1'b1;
            bus.m_read       <= 1'b0;
            bus.m_write      <= 1'b0;
            bus.m_byteenable <= 4'h0;
            tmo_cnt          <= '0;
            state            <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase

      // Commands arriving mid-operation are dropped and flagged
      if (state != S_IDLE && any_strobe) monitor_error <= 1'b1;
    end
  end

endmodule

// File: doc/nios2_cpu_debug_ocimem_ctrl.md
Name: nios2_cpu_debug_ocimem_ctrl

Overview:
Debug-memory access engine downstream of the debug slave sysclk stage. It consumes the synchronized JTAG data word (jdo) and the ocimem take-action strobes, then performs word reads/writes to a local debug RAM or, for out-of-range addresses, to the system bus through a simple master port. It returns MonDReg, monitor_ready and monitor_error to the debug slave for scan-out.

Parameters:
RAM_DEPTH, 256, local debug RAM words (power of 2); word addresses 0..RAM_DEPTH-1 hit RAM
TIMEOUT, 1023, max bus cycles with m_waitrequest high before abort
RESET_ADDR, 0, MonAReg value after reset

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
jdo  in  38  command/data word from debug slave sysclk stage
take_action_ocimem_a  in  1  1-cycle strobe: address load / control
take_action_ocimem_b  in  1  1-cycle strobe: write jdo[31:0] at MonAReg, then increment
take_no_action_ocimem_a  in  1  1-cycle strobe: read at MonAReg, then increment
MonDReg  out  32  last read data
MonAReg  out  30  current word address
monitor_ready  out  1  1 = idle, MonDReg valid
monitor_error  out  1  sticky error (timeout or command while busy)
m_address  out  32  byte address = {MonAReg, 2'b00}
m_read  out  1  bus read request
m_write  out  1  bus write request
m_writedata  out  32  bus write data
m_byteenable  out  4  always 4'hF while m_read or m_write is high, else 0
m_readdata  in  32  bus read data
m_waitrequest  in  1  bus stall

Behaviour:
- Reset (sync, active-high): state IDLE; MonDReg=0; MonAReg=RESET_ADDR; monitor_ready=1; monitor_error=0; m_read=m_write=0; m_writedata=0; timeout counter=0. RAM contents are not cleared.
- Reset asserted mid-operation: all bus requests deassert at that edge; an in-flight RAM write is not committed if reset and its strobe occur in the same cycle.
- States: IDLE, RAM_RD, BUS_RD, BUS_WR.
- IDLE, take_action_ocimem_a:
  - MonAReg <= jdo[29:0].
  - If jdo[35]=1: clear monitor_error.
  - If jdo[34]=1: start a read at the new address (same rules as take_no_action_ocimem_a, applied to jdo[29:0]).
- IDLE, take_action_ocimem_b:
  - RAM hit: RAM write at that edge; MonAReg+1; stay IDLE; monitor_ready stays 1.
  - Miss: m_write=1, m_writedata=jdo[31:0]; go to BUS_WR; monitor_ready=0.
- IDLE, take_no_action_ocimem_a:
  - RAM hit: go to RAM_RD; monitor_ready=0.
  - Miss: m_read=1; go to BUS_RD; monitor_ready=0.
- RAM_RD: synchronous RAM, 1-cycle latency. Next edge: MonDReg <= ram data; MonAReg+1; monitor_ready=1; return to IDLE. Strobe to monitor_ready is 2 cycles.
- BUS_RD/BUS_WR:
  - m_address and m_writedata stay stable while m_waitrequest=1.
  - On the first edge with m_waitrequest=0: drop the request; BUS_RD captures MonDReg <= m_readdata; MonAReg+1; monitor_ready=1; return to IDLE.
  - The counter increments each stalled cycle. When counter==TIMEOUT with m_waitrequest still 1: drop the request; monitor_error=1; MonDReg=32'hDEADDEAD (reads only); MonAReg unchanged; return to IDLE.
- Strobe arriving while not IDLE: ignored and monitor_error=1. The in-flight operation completes normally.
- Simultaneous strobes in IDLE: priority take_action_ocimem_a > take_action_ocimem_b > take_no_action_ocimem_a; lower-priority strobes are dropped silently.
- MonAReg increments modulo 2^30 (0x3FFFFFFF+1 -> 0). RAM hit test is MonAReg < RAM_DEPTH, using full-width compare.
- monitor_error clears only via reset or take_action_ocimem_a with jdo[35]=1.

Test Plan:
- Reset then idle -> monitor_ready=1, monitor_error=0, MonAReg=0, MonDReg=0, no bus activity.
- Addr load 0x10 (jdo[34]=0); write 0xCAFEF00D; addr load 0x10 with jdo[34]=1 -> 2 cycles later monitor_ready=1, MonDReg=0xCAFEF00D, MonAReg=0x11.
- Addr load 0x4000_0000>>2; read; m_waitrequest high 5 cycles; m_readdata=0x12345678 -> m_address=0x4000_0000, m_read held 6 cycles, MonDReg=0x12345678, MonAReg incremented.
- Bus write with m_waitrequest stuck high, TIMEOUT=1023 -> m_write drops after 1024 cycles, monitor_error=1, MonAReg unchanged; addr load with jdo[35]=1 -> error clears.
- take_no_action_ocimem_a during a stalled BUS_RD -> monitor_error=1, the original read completes with correct data.
- MonAReg=0x3FFFFFFF, bus read completes -> MonAReg wraps to 0; take_action_ocimem_a and take_action_ocimem_b in the same cycle -> address loaded, no write issued.
